// File: rtl/color_conv_ctrl.sv
// Job sequencer for the RGB-to-YCbCr streamer: takes one job descriptor,
// clears the streamer, programs the source/sink address generators,
// launches both streams together and reports completion or timeout.

package color_conv_ctrl_pkg;

    // Address-generator control presented to one stream endpoint.
    typedef struct packed {
        logic        req_start;
        logic [31:0] base_addr;
        logic [31:0] trans_size;
        logic [31:0] line_length;
        logic [31:0] line_stride;
        logic [31:0] feat_length;
        logic [31:0] feat_stride;
        logic [31:0] loop_outer;
        logic [1:0]  realign_type;
        logic [31:0] step;
    } ctrl_sourcesink_t;

    // Status returned by one stream endpoint.
    typedef struct packed {
        logic ready_start;
        logic done;
    } flags_sourcesink_t;

endpackage

module color_conv_ctrl
    import color_conv_ctrl_pkg::*;
#(
    parameter int STREAM_WIDTH   = 96,
    parameter int CNT_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [31:0]          src_addr_i,
    input  logic [31:0]          dst_addr_i,
    input  logic [CNT_WIDTH-1:0] n_pixels_i,
    output logic                 clear_o,
    output ctrl_sourcesink_t     source_ctrl_o,
    input  flags_sourcesink_t    source_flags_i,
    output ctrl_sourcesink_t     sink_ctrl_o,
    input  flags_sourcesink_t    sink_flags_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [31:0]          cycles_o
);

    localparam int          PIX_PER_WORD = STREAM_WIDTH / 24;
    localparam logic [31:0] STEP_BYTES   = 32'(STREAM_WIDTH / 8);
    localparam bit          TO_EN        = (TIMEOUT_CYCLES != 0);
    // Value of the RUN counter during the last permitted RUN cycle.
    localparam logic [31:0] TO_LAST      = TO_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LAUNCH,
        S_RUN,
        S_DONE
    } state_t;

    state_t               state_q;
    logic [31:0]          src_addr_q;
    logic [31:0]          dst_addr_q;
    logic [CNT_WIDTH-1:0] n_words_q;
    logic                 cfg_valid_q;
    logic                 clear_q;
    logic                 done_q;
    logic                 err_q;
    logic                 src_done_q;
    logic                 snk_done_q;
    logic [31:0]          cnt_q;
    logic [31:0]          cycles_q;
    logic [31:0]          run_cnt_q;

    // One extra bit on the rounding sum so the maximum pixel count cannot wrap.
    logic [CNT_WIDTH:0]   n_sum;
    logic [CNT_WIDTH-1:0] n_words_d;
    logic [31:0]          cnt_d;
    logic                 launch_fire;
    logic                 src_done_d;
    logic                 snk_done_d;
    logic                 timeout_hit;

    // Word count, saturating cycle count, launch handshake and done tracking.
    always_comb begin
        n_sum       = {1'b0, n_pixels_i} + (CNT_WIDTH+1)'(PIX_PER_WORD - 1);
        n_words_d   = CNT_WIDTH'(n_sum / (CNT_WIDTH+1)'(PIX_PER_WORD));
        cnt_d       = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
        launch_fire = (state_q == S_LAUNCH) && source_flags_i.ready_start
                      && sink_flags_i.ready_start;
        src_done_d  = src_done_q | source_flags_i.done;
        snk_done_d  = snk_done_q | sink_flags_i.done;
        timeout_hit = TO_EN && (run_cnt_q == TO_LAST);
    end

    // Builds the address-generator fields shared by both streams.
    function automatic ctrl_sourcesink_t cfg_fields(input logic [31:0] base,
                                                    input logic [CNT_WIDTH-1:0] nw);
        ctrl_sourcesink_t c;
        c              = '0;
        c.base_addr    = base;
        c.trans_size   = 32'(nw);
        c.line_length  = 32'(nw);
        c.line_stride  = 32'd0;
        c.feat_length  = 32'd1;
        c.feat_stride  = 32'd0;
        c.loop_outer   = 32'd0;
        c.realign_type = 2'd0;
        c.step         = STEP_BYTES;
        return c;
    endfunction

    // Stream control: fields held while a launched job is in flight, start pulse on handshake.
    always_comb begin
        source_ctrl_o = '0;
        sink_ctrl_o   = '0;
        if (cfg_valid_q) begin
            source_ctrl_o = cfg_fields(src_addr_q, n_words_q);
            sink_ctrl_o   = cfg_fields(dst_addr_q, n_words_q);
        end
        source_ctrl_o.req_start = launch_fire;
        sink_ctrl_o.req_start   = launch_fire;
    end

    // Job sequencer: IDLE -> CLEAR -> LAUNCH -> RUN -> DONE, with zero-length and timeout shortcuts.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            src_addr_q  <= '0;
            dst_addr_q  <= '0;
            n_words_q   <= '0;
            cfg_valid_q <= 1'b0;
            clear_q     <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            src_done_q  <= 1'b0;
            snk_done_q  <= 1'b0;
            cnt_q       <= '0;
            cycles_q    <= '0;
            run_cnt_q   <= '0;
        end else begin
            clear_q <= 1'b0;
            done_q  <= 1'b0;
            if (state_q != S_IDLE) begin
                cnt_q <= cnt_d;
            end
            unique case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        src_addr_q <= src_addr_i;
                        dst_addr_q <= dst_addr_i;
                        n_words_q  <= n_words_d;
                        err_q      <= 1'b0;
                        cnt_q      <= '0;
                        clear_q    <= 1'b1;
                        state_q    <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    if (n_words_q == '0) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        cfg_valid_q <= 1'b1;
                        state_q     <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    if (launch_fire) begin
                        run_cnt_q  <= '0;
                        src_done_q <= 1'b0;
                        snk_done_q <= 1'b0;
                        state_q    <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (src_done_d && snk_done_d) begin
                        // A completion arriving in the last allowed cycle beats the watchdog.
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else if (timeout_hit) begin
                        err_q   <= 1'b1;
                        clear_q <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        src_done_q <= src_done_d;
                        snk_done_q <= snk_done_d;
                        if (TO_EN) begin
                            run_cnt_q <= run_cnt_q + 32'd1;
                        end
                    end
                end
                S_DONE: begin
                    // The DONE cycle itself belongs to the job, hence the incremented count.
                    cycles_q    <= cnt_d;
                    src_done_q  <= 1'b0;
                    snk_done_q  <= 1'b0;
                    cfg_valid_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign clear_o  = clear_q;
    assign done_o   = done_q;
    assign err_o    = err_q;
    assign cycles_o = cycles_q;
    assign busy_o   = (state_q != S_IDLE);

endmodule

// File: tb/tb_color_conv_ctrl.sv
// Self-checking bench for color_conv_ctrl: directed and random jobs, each
// checked cycle by cycle against a timeline computed from the job parameters.
module tb_color_conv_ctrl;
    import color_conv_ctrl_pkg::*;

    localparam int T = 20;

    logic              clk      = 1'b0;
    logic              rst_n    = 1'b0;
    logic              start    = 1'b0;
    logic [31:0]       src_addr = '0;
    logic [31:0]       dst_addr = '0;
    logic [15:0]       n_pix    = '0;
    ctrl_sourcesink_t  src_ctrl;
    ctrl_sourcesink_t  snk_ctrl;
    flags_sourcesink_t src_flags = '0;
    flags_sourcesink_t snk_flags = '0;
    logic              clear;
    logic              busy;
    logic              done;
    logic              err;
    logic [31:0]       cycles;

    int          n_assert    = 0;
    int          n_fail      = 0;
    logic        prev_err    = 1'b0;
    logic [31:0] prev_cycles = '0;

    always #5 clk = ~clk;

    color_conv_ctrl #(
        .STREAM_WIDTH   (96),
        .CNT_WIDTH      (16),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .start_i        (start),
        .src_addr_i     (src_addr),
        .dst_addr_i     (dst_addr),
        .n_pixels_i     (n_pix),
        .clear_o        (clear),
        .source_ctrl_o  (src_ctrl),
        .source_flags_i (src_flags),
        .sink_ctrl_o    (snk_ctrl),
        .sink_flags_i   (snk_flags),
        .busy_o         (busy),
        .done_o         (done),
        .err_o          (err),
        .cycles_o       (cycles)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctrl(input string tag, input ctrl_sourcesink_t obs, input ctrl_sourcesink_t exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed req=%b base=%h size=%0d len=%0d step=%0d feat=%0d expected req=%b base=%h size=%0d len=%0d step=%0d feat=%0d",
                   tag, obs.req_start, obs.base_addr, obs.trans_size, obs.line_length, obs.step, obs.feat_length,
                   exp.req_start, exp.base_addr, exp.trans_size, exp.line_length, exp.step, exp.feat_length);
        end
    endtask

    // Expected stream control word from the job parameters.
    function automatic ctrl_sourcesink_t exp_ctrl(input bit valid, input logic [31:0] base,
                                                  input int nw, input bit req);
        ctrl_sourcesink_t c;
        c = '0;
        if (valid) begin
            c.base_addr   = base;
            c.trans_size  = 32'(nw);
            c.line_length = 32'(nw);
            c.feat_length = 32'd1;
            c.step        = 32'(96 / 8);
        end
        c.req_start = req;
        return c;
    endfunction

    task automatic chk_zero(input string tag);
        chk1({tag, "_clear"}, clear, 1'b0);
        chk1({tag, "_done"}, done, 1'b0);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk1({tag, "_err"}, err, 1'b0);
        chk32({tag, "_cycles"}, cycles, 32'd0);
        chk_ctrl({tag, "_src_ctrl"}, src_ctrl, '0);
        chk_ctrl({tag, "_snk_ctrl"}, snk_ctrl, '0);
    endtask

    // Runs one job. rs/rk: cycles the source/sink ready_start lags LAUNCH entry.
    // sd/kd: done pulse offset after the launch cycle (0 = never). noisy: extra
    // start pulses and input churn while busy.
    task automatic run_job(input logic [31:0] src, input logic [31:0] dst, input int n,
                           input int rs, input int rk, input int sd, input int kd, input bit noisy);
        int nw;
        int lc;
        int dc;
        bit to;
        bit valid;
        bit req;
        nw = (n + 3) / 4;
        lc = 2 + ((rs > rk) ? rs : rk);
        if (nw == 0) begin
            dc = 2;
            to = 1'b0;
        end else if (sd >= 1 && sd <= T && kd >= 1 && kd <= T) begin
            dc = lc + ((sd > kd) ? sd : kd) + 1;
            to = 1'b0;
        end else begin
            dc = lc + T + 1;
            to = 1'b1;
        end
        for (int k = 0; k <= dc + 1; k++) begin
            start    = (k == 0) || (noisy && k >= 1 && k <= dc && $urandom_range(1, 0) == 1);
            src_addr = (k == 0) ? src : $urandom;
            dst_addr = (k == 0) ? dst : $urandom;
            n_pix    = (k == 0) ? 16'(n) : 16'($urandom);
            src_flags.ready_start = (k >= 2 + rs);
            snk_flags.ready_start = (k >= 2 + rk);
            src_flags.done        = (sd != 0 && k == lc + sd);
            snk_flags.done        = (kd != 0 && k == lc + kd);
            #1;
            valid = (nw != 0) && (k >= 2) && (k <= dc);
            req   = (nw != 0) && (k == lc);
            chk1("clear", clear, (k == 1) || (to && k == dc));
            chk1("done", done, k == dc);
            chk1("busy", busy, k >= 1 && k <= dc);
            chk1("err", err, (k == 0) ? prev_err : ((k < dc) ? 1'b0 : to));
            chk_ctrl("src_ctrl", src_ctrl, exp_ctrl(valid, src, nw, req));
            chk_ctrl("snk_ctrl", snk_ctrl, exp_ctrl(valid, dst, nw, req));
            if (k == 0) chk32("cycles_prev", cycles, prev_cycles);
            if (k == dc + 1) chk32("cycles", cycles, 32'(dc));
            @(posedge clk);
            #1;
        end
        start     = 1'b0;
        src_flags = '0;
        snk_flags = '0;
        $display("job src=%h dst=%h n_pixels=%0d words=%0d launch_cycle=%0d done_cycle=%0d timeout=%0d",
                 src, dst, n, nw, lc, dc, to);
        prev_err    = to;
        prev_cycles = 32'(dc);
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Nominal job.
        run_job(32'h1000, 32'h2000, 16, 0, 0, 10, 14, 1'b0);
        // Rounding.
        run_job(32'h3000, 32'h4000, 5, 0, 0, 3, 3, 1'b0);
        run_job(32'h3100, 32'h4100, 4, 0, 0, 2, 1, 1'b0);
        // Zero length.
        run_job(32'h5000, 32'h6000, 0, 0, 0, 3, 3, 1'b0);
        // Stalled launch then sink finishing first.
        run_job(32'h7000, 32'h8000, 33, 0, 7, 5, 2, 1'b0);
        // Same-cycle done after a source stall.
        run_job(32'h7100, 32'h8100, 12, 3, 0, 6, 6, 1'b0);
        // Timeout with no done pulses, then with one stream finished.
        run_job(32'h9000, 32'hA000, 40, 0, 0, 0, 0, 1'b0);
        run_job(32'h9100, 32'hA100, 40, 1, 0, 5, 0, 1'b0);
        // Completion in the final allowed RUN cycle, clearing the sticky error.
        run_job(32'h9200, 32'hA200, 8, 0, 0, T, 4, 1'b0);
        // Start pulses while busy, then the maximum pixel count.
        run_job(32'hB000, 32'hC000, 100, 2, 1, 8, 9, 1'b1);
        run_job(32'hD000, 32'hE000, 65535, 0, 0, 4, 4, 1'b1);

        // Reset during RUN.
        src_addr = 32'hF000;
        dst_addr = 32'hF100;
        n_pix    = 16'd8;
        start    = 1'b1;
        src_flags.ready_start = 1'b1;
        snk_flags.ready_start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk1("mid_run_busy", busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("mid_run_reset");
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        src_flags = '0;
        snk_flags = '0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            chk1("post_reset_done", done, 1'b0);
            chk1("post_reset_busy", busy, 1'b0);
        end
        $display("job reset during RUN, no completion expected");
        prev_err    = 1'b0;
        prev_cycles = '0;
        run_job(32'h1234_5678, 32'h9ABC_DEF0, 21, 1, 2, 3, 7, 1'b0);

        // Random jobs.
        for (int j = 0; j < 20; j++) begin
            n = ($urandom_range(3, 0) == 0) ? int'($urandom_range(3, 0)) : int'($urandom_range(65535, 0));
            run_job($urandom, $urandom, n,
                    int'($urandom_range(4, 0)), int'($urandom_range(4, 0)),
                    int'($urandom_range(22, 0)), int'($urandom_range(22, 0)),
                    1'($urandom_range(1, 0)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/color_conv_ctrl.md
Name: color_conv_ctrl

Overview:
- Job sequencer for the RGB-to-YCbCr streamer.
- Accepts one job descriptor: source address, destination address, pixel count. Clears the streamer, programs the source and sink address generators, and starts both streams together.
- Tracks both done flags, counts cycles, runs a timeout watchdog, and raises a one-cycle completion event.
- Sits between the register file / ctrl slave and the streamer.

Parameters:
- STREAM_WIDTH, 96, stream word width in bits; PIX_PER_WORD = STREAM_WIDTH/24 (4 at default).
- CNT_WIDTH, 16, width of the pixel-count input and the word counters.
- TIMEOUT_CYCLES, 65535, maximum RUN-state cycles before abort; 0 disables the watchdog.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- start_i  in  1  job start pulse; sampled only in IDLE
- src_addr_i  in  32  RGB source byte address, latched at start
- dst_addr_i  in  32  YCbCr destination byte address, latched at start
- n_pixels_i  in  CNT_WIDTH  pixel count, latched at start
- clear_o  out  1  streamer clear pulse
- source_ctrl_o  out  ctrl_sourcesink_t  source stream control
- source_flags_i  in  flags_sourcesink_t  source stream flags
- sink_ctrl_o  out  ctrl_sourcesink_t  sink stream control
- sink_flags_i  in  flags_sourcesink_t  sink stream flags
- busy_o  out  1  high in any state other than IDLE
- done_o  out  1  one-cycle job-end event
- err_o  out  1  sticky timeout flag
- cycles_o  out  32  cycle count of the last job

Behaviour:
- Reset values: all outputs 0, state IDLE.
  - ctrl structs all-zero.
  - err_o, cycles_o and latched config registers 0.
- start_i is latched only in IDLE and ignored in every other state.
  - Word count: n_words = ceil(n_pixels_i / PIX_PER_WORD), computed as (n + PIX_PER_WORD-1)/PIX_PER_WORD, CNT_WIDTH bits.
  - Intermediate sum is CNT_WIDTH+1 bits; no overflow at max n.
- Address-generator fields, identical for source and sink except base_addr:
  - base_addr = latched src/dst address
  - trans_size = n_words
  - line_length = n_words
  - line_stride = 0
  - feat_length = 1
  - feat_stride = 0
  - loop_outer = 0
  - realign_type = 0
  - step = STREAM_WIDTH/8
  - These fields are held stable from LAUNCH until the return to IDLE.
- FSM:
  - IDLE: on start_i, latch config, clear err_o, zero the cycle counter, go to CLEAR.
  - CLEAR: clear_o = 1 for exactly one cycle. Next state is DONE if n_words == 0, else LAUNCH.
  - LAUNCH: wait until source_flags_i.ready_start and sink_flags_i.ready_start are both 1.
    - In that cycle assert req_start = 1 on both ctrl outputs simultaneously (single-cycle pulse).
    - Next state RUN.
  - RUN: per-stream sticky bits src_done and snk_done are set on the respective flags.done pulse.
    - Done pulses may arrive in any order or in the same cycle.
    - When both bits are set, go to DONE.
    - Watchdog: if TIMEOUT_CYCLES != 0 and RUN has lasted TIMEOUT_CYCLES cycles, set err_o, pulse clear_o once, go to DONE.
  - DONE: done_o = 1 for one cycle, cycles_o <= counter value, sticky done bits cleared, go to IDLE.
- Cycle counter: increments every non-IDLE cycle, starting with CLEAR; saturates at 2^32-1.
- busy_o = (state != IDLE); it falls in the cycle after done_o.
- err_o stays set until the next accepted start_i.
- Reset asserted mid-job: immediate return to IDLE with all outputs zero. No done_o is produced.

Test Plan:
- Nominal job, src 0x1000, dst 0x2000, n_pixels 16, both ready_start high:
  - required: clear_o at cycle 1, req_start at cycle 2, trans_size = 4, step = 12, base_addr values correct.
  - source done at +10 and sink done at +14 → done_o one cycle after sink done, err_o 0.
- Rounding, n_pixels 5: trans_size = 2. n_pixels 4: trans_size = 1.
- Zero length, n_pixels 0: clear_o, then done_o two cycles after start, req_start never asserted, cycles_o = 2.
- Stalled launch, sink ready_start low for 7 cycles: req_start on both streams only in the first cycle both are ready, both pulses in the same cycle. Then sink done before source done, and same-cycle done → each case completes normally.
- Timeout with TIMEOUT_CYCLES = 20 and no done pulses: err_o set, clear_o pulse, done_o after 20 RUN cycles. Next start clears err_o.
- Robustness: start_i while busy has no effect. rst_ni low during RUN → outputs zero, IDLE, no done_o. A subsequent job runs normally.
